// File: rtl/axis_dwc_pkg.sv
// Purpose : shared types and sizing for the 512<->64 AXI-Stream width converters.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
//
// Shared by the 64-to-512 collector and the 512-to-64 serializer so both
// agree on lane count, lane index width and the two-state control encoding.
package axis_dwc_pkg;

    // Lanes per wide word and the width of a lane index.
    localparam int NUM_OF_BEATS = 512 / 64;
    localparam int LANE_W       = $clog2(NUM_OF_BEATS);

    // EMPTY: holding register free, upstream may load.
    // SEND : holding register owns a word, lanes are being emitted.
    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } dwc_state_t;

endpackage

// File: rtl/axis_lane_last_finder.sv
// Purpose : priority encoder, per-lane keep bits -> highest lane with any keep set.
// Latency : combinational, 0 cycles.
// Backpr. : none; pure function of the keep vector.
//
// Ports:
//   keep      in   NUM_LANES*KEEP_PER_LANE  byte keep of one wide word
//   last_lane out  LW                       index of highest lane with nonzero keep (0 if none)
//   all_zero  out  1                        no keep bit set anywhere in the word
module axis_lane_last_finder #(
    parameter int NUM_LANES     = 8,
    parameter int KEEP_PER_LANE = 8,
    parameter int LW            = 3
) (
    input  logic [NUM_LANES*KEEP_PER_LANE-1:0] keep,
    output logic [LW-1:0]                      last_lane,
    output logic                               all_zero
);

    // Ascending scan: the last lane that matches wins, so the result is the
    // highest populated lane.
    always_comb begin
        last_lane = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (|keep[k*KEEP_PER_LANE +: KEEP_PER_LANE]) begin
                last_lane = LW'(k);
            end
        end
    end

    assign all_zero = ~|keep;

endmodule

// File: rtl/axis_512_to_64_serializer.sv
// Purpose : splits each 512-bit AXI-Stream word into 8 x 64-bit beats, bits [63:0] first.
// Latency : input handshake in cycle N -> first output beat valid in N+1; 1 beat/cycle, no bubble between words.
// Backpr. : M_AXIS_TREADY low freezes the current beat; S_AXIS_TREADY only rises on the final lane (or when empty).
//
// Ports:
//   aclk, areset           clock (rising edge) and asynchronous active-high reset
//   S_AXIS_TDATA/TVALID/TLAST/TREADY   wide slave stream from the LDPC core
//   M_AXIS_TDATA/TVALID/TLAST/TREADY   narrow master stream toward DMA S2MM
//   S_AXIS_TKEEP, M_AXIS_TKEEP         only with AXIS_SERIALIZER_TKEEP_EN defined
//
// Optional build macro AXIS_SERIALIZER_TKEEP_EN: carries TKEEP through and,
// on a TLAST word, stops after the highest lane holding any kept byte (an
// all-zero keep still emits lane 0 with TKEEP=0 and TLAST=1). Without it,
// every word always produces all lanes.
//
// S_AXIS_TREADY in SEND is a combinational function of M_AXIS_TREADY; that is
// the only input-to-output combinational path and it is what lets a new word
// load on the same edge the final lane leaves, keeping the output gapless.
module axis_512_to_64_serializer
    import axis_dwc_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 512,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int NUM_OF_BEATS           = C_S00_AXIS_TDATA_WIDTH / C_M00_AXIS_TDATA_WIDTH
) (
    input  logic                                  aclk,
    input  logic                                  areset,

    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic                                  S_AXIS_TVALID,
    input  logic                                  S_AXIS_TLAST,
    output logic                                  S_AXIS_TREADY,

    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic                                  M_AXIS_TVALID,
    output logic                                  M_AXIS_TLAST,
`ifdef AXIS_SERIALIZER_TKEEP_EN
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
`endif
    input  logic                                  M_AXIS_TREADY
);

    localparam int LW        = (NUM_OF_BEATS > 1) ? $clog2(NUM_OF_BEATS) : 1;
    localparam int LANE_BITS = C_M00_AXIS_TDATA_WIDTH;
    localparam logic [LW-1:0] LAST_LANE = LW'(NUM_OF_BEATS - 1);

    dwc_state_t                        state;
    logic [C_S00_AXIS_TDATA_WIDTH-1:0] hold;
    logic [LW-1:0]                     lane;
    logic                              last_flag;
    // Clears with reset and sets on the first clock afterwards, so the
    // slave side never advertises ready while reset is asserted.
    logic                              out_of_reset;

    logic [LW-1:0]                     end_lane;   // final lane to emit for the held word
    logic                              at_end;
    logic                              s_hs;
    logic                              m_hs;

    //------------------------------------------------------------------
    // Handshakes and flow control
    //------------------------------------------------------------------
    assign at_end        = (lane == end_lane);
    assign M_AXIS_TVALID = (state == SEND);
    assign S_AXIS_TREADY = out_of_reset &&
                           ((state == EMPTY) || (at_end && M_AXIS_TREADY));
    assign s_hs          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign m_hs          = M_AXIS_TVALID && M_AXIS_TREADY;

    //------------------------------------------------------------------
    // Output beat: everything below is a mux of registered state, so it is
    // stable for as long as the lane does not advance.
    //------------------------------------------------------------------
    assign M_AXIS_TDATA = hold[int'(lane)*LANE_BITS +: LANE_BITS];
    assign M_AXIS_TLAST = last_flag && at_end;

    //------------------------------------------------------------------
    // Control FSM: holding register, lane counter and packet-end flag.
    // A slave handshake in SEND can only happen on the final lane together
    // with a master handshake, so it doubles as the zero-bubble reload.
    //------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state        <= EMPTY;
            hold         <= '0;
            lane         <= '0;
            last_flag    <= 1'b0;
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            case (state)
                EMPTY: begin
                    if (s_hs) begin
                        hold      <= S_AXIS_TDATA;
                        last_flag <= S_AXIS_TLAST;
                        lane      <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (m_hs) begin
                        if (!at_end) begin
                            lane <= lane + 1'b1;
                        end else if (s_hs) begin
                            hold      <= S_AXIS_TDATA;
                            last_flag <= S_AXIS_TLAST;
                            lane      <= '0;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

`ifdef AXIS_SERIALIZER_TKEEP_EN
    //------------------------------------------------------------------
    // Keep path: keep is captured alongside data, and the final lane of a
    // TLAST word is decided at load time so the beat-level compare above
    // stays a single equality.
    //------------------------------------------------------------------
    localparam int KEEP_PER_LANE = C_M00_AXIS_TDATA_WIDTH / 8;

    logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] keep_hold;
    logic [LW-1:0]                       end_lane_q;
    logic [LW-1:0]                       found_lane;
    logic                                keep_all_zero;
    logic [LW-1:0]                       load_end_lane;

    axis_lane_last_finder #(
        .NUM_LANES     (NUM_OF_BEATS),
        .KEEP_PER_LANE (KEEP_PER_LANE),
        .LW            (LW)
    ) u_last_finder (
        .keep      (S_AXIS_TKEEP),
        .last_lane (found_lane),
        .all_zero  (keep_all_zero)
    );

    // Non-TLAST words always run to the top lane regardless of keep.
    always_comb begin
        load_end_lane = LAST_LANE;
        if (S_AXIS_TLAST) begin
            load_end_lane = keep_all_zero ? '0 : found_lane;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            keep_hold  <= '0;
            end_lane_q <= LAST_LANE;
        end else if (s_hs) begin
            keep_hold  <= S_AXIS_TKEEP;
            end_lane_q <= load_end_lane;
        end
    end

    assign end_lane     = end_lane_q;
    assign M_AXIS_TKEEP = keep_hold[int'(lane)*KEEP_PER_LANE +: KEEP_PER_LANE];
`else
    assign end_lane = LAST_LANE;
`endif

endmodule

// File: tb/tb_axis_512_to_64_serializer.sv
// Bench for axis_512_to_64_serializer: random and directed words are queued,
// a stream-level model expands each accepted word into its expected beats,
// and every cycle the DUT outputs are compared against that beat queue.
module tb_axis_512_to_64_serializer;

    localparam int NB = 8;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [511:0] S_AXIS_TDATA = '0;
    logic         S_AXIS_TVALID = 1'b0;
    logic         S_AXIS_TLAST = 1'b0;
    logic         S_AXIS_TREADY;
    logic [63:0]  M_AXIS_TDATA;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TREADY = 1'b0;
`ifdef AXIS_SERIALIZER_TKEEP_EN
    logic [63:0]  S_AXIS_TKEEP = '0;
    logic [7:0]   M_AXIS_TKEEP;
`endif

    axis_512_to_64_serializer dut (
        .aclk          (aclk),
        .areset        (areset),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
`ifdef AXIS_SERIALIZER_TKEEP_EN
        .S_AXIS_TKEEP  (S_AXIS_TKEEP),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
`endif
        .M_AXIS_TREADY (M_AXIS_TREADY)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] d;
        logic        l;
`ifdef AXIS_SERIALIZER_TKEEP_EN
        logic [7:0]  k;
`endif
    } beat_t;

    typedef struct {
        logic [511:0] d;
        logic         l;
`ifdef AXIS_SERIALIZER_TKEEP_EN
        logic [63:0]  k;
`endif
    } word_t;

    beat_t       exp_q[$];     // beats the DUT still owes, in order
    word_t       in_q[$];      // words waiting to be offered upstream
    logic [63:0] out_d_log[$];
    logic        out_l_log[$];
`ifdef AXIS_SERIALIZER_TKEEP_EN
    logic [7:0]  out_k_log[$];
`endif
    int          beat_cyc[$];  // cycle number of every output handshake
    int          shs_cyc[$];   // cycle number of every input handshake
    int          srdy_busy_cyc[$]; // cycles with S_TREADY high while a beat is valid

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    bit rand_ready = 0;
    bit gap_mode = 0;
    bit presenting = 0;
    bit prev_stall = 0;
    logic [63:0] prev_d;
    logic        prev_l;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Stream-level model: a word becomes NB lanes, low lane first; a TLAST
    // word with keep stops at its highest populated lane (lane 0 if none).
    function automatic void push_word(input word_t w);
        int n = NB;
        beat_t b;
`ifdef AXIS_SERIALIZER_TKEEP_EN
        if (w.l) begin
            n = 1;
            for (int k = 0; k < NB; k++)
                if (w.k[k*8 +: 8] != 8'h00) n = k + 1;
        end
`endif
        for (int k = 0; k < n; k++) begin
            b.d = w.d[k*64 +: 64];
            b.l = w.l && (k == n - 1);
`ifdef AXIS_SERIALIZER_TKEEP_EN
            b.k = w.k[k*8 +: 8];
`endif
            exp_q.push_back(b);
        end
    endfunction

    function automatic word_t pattern_word(input logic last);
        word_t w;
        for (int k = 0; k < NB; k++) w.d[k*64 +: 64] = 64'h0101_0101_0101_0101 * (k + 1);
        w.l = last;
`ifdef AXIS_SERIALIZER_TKEEP_EN
        w.k = '1;
`endif
        return w;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < 16; i++) w.d[i*32 +: 32] = $urandom();
        w.l = ($urandom_range(0, 2) == 0);
`ifdef AXIS_SERIALIZER_TKEEP_EN
        w.k = {$urandom(), $urandom()};
        if ($urandom_range(0, 1) == 0) begin
            int n = $urandom_range(0, NB);
            for (int k = 0; k < NB; k++) if (k >= n) w.k[k*8 +: 8] = 8'h00;
        end
`endif
        return w;
    endfunction

    // One clock: drive at the falling edge, settle, compare, then account for
    // whichever handshakes the next rising edge will take.
    task automatic cycle();
        @(negedge aclk);
        cyc++;
        M_AXIS_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!presenting && in_q.size() != 0 && (!gap_mode || $urandom_range(0, 2) == 0))
            presenting = 1;
        if (presenting) begin
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = in_q[0].d;
            S_AXIS_TLAST  = in_q[0].l;
`ifdef AXIS_SERIALIZER_TKEEP_EN
            S_AXIS_TKEEP  = in_q[0].k;
`endif
        end else begin
            S_AXIS_TVALID = 1'b0;
            S_AXIS_TDATA  = {16{32'hDEAD_BEEF}};
            S_AXIS_TLAST  = 1'b1;
        end
        #1;
        chk("tvalid", M_AXIS_TVALID, exp_q.size() != 0);
        chk("s_tready", S_AXIS_TREADY,
            (exp_q.size() == 0) || (exp_q.size() == 1 && M_AXIS_TREADY));
        if (M_AXIS_TVALID && exp_q.size() != 0) begin
            chk("tdata", M_AXIS_TDATA, exp_q[0].d);
            chk("tlast", M_AXIS_TLAST, exp_q[0].l);
`ifdef AXIS_SERIALIZER_TKEEP_EN
            chk("tkeep", M_AXIS_TKEEP, exp_q[0].k);
`endif
        end
        if (prev_stall) begin
            chk("stall_valid", M_AXIS_TVALID, 1'b1);
            chk("stall_data", M_AXIS_TDATA, prev_d);
            chk("stall_last", M_AXIS_TLAST, prev_l);
        end
        prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
        prev_d = M_AXIS_TDATA;
        prev_l = M_AXIS_TLAST;
        if (M_AXIS_TVALID && S_AXIS_TREADY) srdy_busy_cyc.push_back(cyc);
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            out_d_log.push_back(M_AXIS_TDATA);
            out_l_log.push_back(M_AXIS_TLAST);
`ifdef AXIS_SERIALIZER_TKEEP_EN
            out_k_log.push_back(M_AXIS_TKEEP);
`endif
            beat_cyc.push_back(cyc);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (S_AXIS_TVALID && S_AXIS_TREADY && in_q.size() != 0) begin
            push_word(in_q[0]);
            void'(in_q.pop_front());
            shs_cyc.push_back(cyc);
            presenting = 0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || in_q.size() != 0) && n < 3000) begin
            cycle();
            n++;
        end
        cycle();
        chk("drain_done", exp_q.size() + in_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int sbase;
        int bbase;
        int cnt;

        // Reset state
        #3;
        chk("rst_tvalid", M_AXIS_TVALID, 1'b0);
        chk("rst_tready", S_AXIS_TREADY, 1'b0);
        chk("rst_tdata", M_AXIS_TDATA, 64'h0);
        chk("rst_tlast", M_AXIS_TLAST, 1'b0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;

        // Single pattern word, TLAST=1
        base = out_d_log.size();
        in_q.push_back(pattern_word(1'b1));
        drain();
        chk("single_count", out_d_log.size() - base, NB);
        if (out_d_log.size() - base == NB) begin
            chk("single_lane0", out_d_log[base], 64'h0101_0101_0101_0101);
            chk("single_lane3", out_d_log[base+3], 64'h0404_0404_0404_0404);
            chk("single_lane7", out_d_log[base+7], 64'h0808_0808_0808_0808);
            chk("single_last6", out_l_log[base+6], 1'b0);
            chk("single_last7", out_l_log[base+7], 1'b1);
        end

        // Back-to-back words: TLAST=0 then TLAST=1
        base  = out_d_log.size();
        sbase = shs_cyc.size();
        bbase = srdy_busy_cyc.size();
        in_q.push_back(pattern_word(1'b0));
        in_q.push_back(rand_word());
        in_q[1].l = 1'b1;
`ifdef AXIS_SERIALIZER_TKEEP_EN
        in_q[1].k = '1;
`endif
        drain();
        chk("b2b_count", out_d_log.size() - base, 2 * NB);
        if (out_d_log.size() - base == 2 * NB && shs_cyc.size() - sbase == 2) begin
            chk("b2b_gapless", beat_cyc[base+15] - beat_cyc[base], 15);
            chk("b2b_last8", out_l_log[base+7], 1'b0);
            chk("b2b_last16", out_l_log[base+15], 1'b1);
            chk("b2b_lane8_data", out_d_log[base+7], 64'h0808_0808_0808_0808);
            chk("b2b_reload_beat8", shs_cyc[sbase+1], beat_cyc[base+7]);
            cnt = srdy_busy_cyc.size() - bbase;
            chk("b2b_sready_pulses", cnt, 2);
            if (cnt == 2) begin
                chk("b2b_sready_at8", srdy_busy_cyc[bbase], beat_cyc[base+7]);
                chk("b2b_sready_at16", srdy_busy_cyc[bbase+1], beat_cyc[base+15]);
            end
        end

        // Random data with 50% output backpressure
        rand_ready = 1;
        for (int i = 0; i < 30; i++) in_q.push_back(rand_word());
        drain();

        // Random data, backpressure and upstream gaps
        gap_mode = 1;
        for (int i = 0; i < 30; i++) in_q.push_back(rand_word());
        drain();
        gap_mode = 0;
        rand_ready = 0;

        // Asynchronous reset in the middle of a word (lane 3 on the output)
        base = out_d_log.size();
        in_q.push_back(rand_word());
        for (int i = 0; i < 50 && out_d_log.size() - base < 3; i++) cycle();
        chk("midrst_reach_lane3", out_d_log.size() - base, 3);
        @(negedge aclk);
        #2 areset = 1'b1;
        #1;
        chk("midrst_tvalid", M_AXIS_TVALID, 1'b0);
        chk("midrst_tready", S_AXIS_TREADY, 1'b0);
        chk("midrst_tdata", M_AXIS_TDATA, 64'h0);
        chk("midrst_tlast", M_AXIS_TLAST, 1'b0);
        exp_q.delete();
        in_q.delete();
        presenting = 0;
        prev_stall = 0;
        S_AXIS_TVALID = 1'b0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        base = out_d_log.size();
        in_q.push_back(pattern_word(1'b1));
        drain();
        chk("postrst_count", out_d_log.size() - base, NB);
        if (out_d_log.size() - base == NB)
            chk("postrst_lane0", out_d_log[base], 64'h0101_0101_0101_0101);

`ifdef AXIS_SERIALIZER_TKEEP_EN
        // Partial keep on a TLAST word: three lanes
        base = out_d_log.size();
        in_q.push_back(pattern_word(1'b1));
        in_q[0].k = 64'h0000_0000_00FF_FFFF;
        drain();
        chk("keep3_count", out_d_log.size() - base, 3);
        if (out_d_log.size() - base == 3) begin
            chk("keep3_tkeep", out_k_log[base+2], 8'hFF);
            chk("keep3_tlast", out_l_log[base+2], 1'b1);
            chk("keep3_data", out_d_log[base+2], 64'h0303_0303_0303_0303);
        end
        // All-zero keep on a TLAST word: one empty lane
        base = out_d_log.size();
        in_q.push_back(pattern_word(1'b1));
        in_q[0].k = 64'h0;
        drain();
        chk("keep0_count", out_d_log.size() - base, 1);
        if (out_d_log.size() - base == 1) begin
            chk("keep0_tkeep", out_k_log[base], 8'h00);
            chk("keep0_tlast", out_l_log[base], 1'b1);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
